// File: rtl/axi_slv_wr_responder_if.sv
// AW/W/B handshake bundle between the bench-side write driver and the responder.
// master: drives AW request, W beats, W stall and B ready.
// slave : drives AW ready, W ready and the B response channel.
interface axi_slv_wr_responder_if #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_ID_W   = 4,
    parameter int unsigned AXI_DATA_W = 32
);
    logic                    in_awvalid;
    logic                    out_awready;
    logic [AXI_ADDR_W-1:0]   in_awaddr;
    logic [3:0]              in_awlen;
    logic [AXI_ID_W-1:0]     in_awid;

    logic                    in_wvalid;
    logic                    out_wready;
    logic                    in_wlast;
    logic [AXI_ID_W-1:0]     in_wid;
    logic [AXI_DATA_W-1:0]   in_wdata;
    logic [AXI_DATA_W/8-1:0] in_wstrb;
    logic                    in_wstall;

    logic                    out_bvalid;
    logic                    in_bready;
    logic [AXI_ID_W-1:0]     out_bid;
    logic [1:0]              out_bresp;

    modport master (
        output in_awvalid, in_awaddr, in_awlen, in_awid,
        output in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb, in_wstall,
        output in_bready,
        input  out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );

    modport slave (
        input  in_awvalid, in_awaddr, in_awlen, in_awid,
        input  in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb, in_wstall,
        input  in_bready,
        output out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );
endinterface

// File: rtl/axi_slv_wr_responder.sv
// AXI3 write-side slave responder: queues AW requests, consumes W beats per
// queued burst, and returns one B (OKAY/SLVERR) per burst through a FIFO.
// Ports:
//   aclk, arst        clock, asynchronous active-high reset
//   bus (slave)       AW/W/B handshake bundle (see axi_slv_wr_responder_if)
//   out_err_cnt       saturating count of SLVERR responses pushed
//   out_wdata_xor     running XOR of strobed bytes of accepted W beats
module axi_slv_wr_responder #(
    parameter int unsigned AXI_ADDR_W      = 32,
    parameter int unsigned AXI_ID_W        = 4,
    parameter int unsigned AXI_DATA_W      = 32,
    parameter int unsigned SLV_OSTDREQ_NUM = 4,
    parameter int unsigned B_FIFO_DEPTH    = 4
) (
    input  logic                  aclk,
    input  logic                  arst,
    axi_slv_wr_responder_if.slave bus,
    output logic [7:0]            out_err_cnt,
    output logic [AXI_DATA_W-1:0] out_wdata_xor
);
    localparam int unsigned AW_PTR_W = $clog2(SLV_OSTDREQ_NUM);
    localparam int unsigned B_PTR_W  = $clog2(B_FIFO_DEPTH);
    localparam int unsigned STRB_W   = AXI_DATA_W / 8;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [3:0]          len;
    } aw_ent_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } b_ent_t;

    aw_ent_t               aw_mem [SLV_OSTDREQ_NUM];
    logic [AW_PTR_W-1:0]   aw_wr_ptr, aw_rd_ptr;
    logic [AW_PTR_W:0]     aw_cnt, aw_cnt_nxt;
    b_ent_t                b_mem [B_FIFO_DEPTH];
    logic [B_PTR_W-1:0]    b_wr_ptr, b_rd_ptr;
    logic [B_PTR_W:0]      b_cnt, b_cnt_nxt;
    logic [3:0]            cnt;
    logic                  id_err_q;
    logic                  awready_q;

    logic                  aw_empty, b_full, b_empty;
    logic                  wready_c, w_acc, at_len, id_mis, burst_end, burst_err;
    logic                  aw_push, aw_pop, b_push, b_pop;
    aw_ent_t               aw_head;
    logic [AXI_DATA_W-1:0] strb_mask;

    // Address is accepted but never inspected.
    logic unused_awaddr;
    assign unused_awaddr = ^bus.in_awaddr;

    // Handshake decode and burst bookkeeping from registered queue state.
    always_comb begin
        aw_empty  = (aw_cnt == '0);
        b_empty   = (b_cnt == '0);
        b_full    = (b_cnt == (B_PTR_W+1)'(B_FIFO_DEPTH));
        aw_head   = aw_mem[aw_rd_ptr];
        wready_c  = !aw_empty && !b_full && !bus.in_wstall;
        w_acc     = bus.in_wvalid && wready_c;
        at_len    = (cnt == aw_head.len);
        id_mis    = (bus.in_wid != aw_head.id);
        burst_end = w_acc && (bus.in_wlast || at_len);
        // cnt never exceeds len, so !at_len means an early last.
        burst_err = id_err_q || id_mis || (bus.in_wlast != at_len);
        aw_push   = bus.in_awvalid && awready_q;
        aw_pop    = burst_end;
        b_push    = burst_end;
        b_pop     = !b_empty && bus.in_bready;

        aw_cnt_nxt = aw_cnt;
        if (aw_push && !aw_pop) begin
            aw_cnt_nxt = aw_cnt + (AW_PTR_W+1)'(1);
        end else if (!aw_push && aw_pop) begin
            aw_cnt_nxt = aw_cnt - (AW_PTR_W+1)'(1);
        end

        b_cnt_nxt = b_cnt;
        if (b_push && !b_pop) begin
            b_cnt_nxt = b_cnt + (B_PTR_W+1)'(1);
        end else if (!b_push && b_pop) begin
            b_cnt_nxt = b_cnt - (B_PTR_W+1)'(1);
        end

        strb_mask = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            strb_mask[i*8 +: 8] = {8{bus.in_wstrb[i]}};
        end
    end

    assign bus.out_awready = awready_q;
    assign bus.out_wready  = wready_c;
    assign bus.out_bvalid  = !b_empty;
    assign bus.out_bid     = b_mem[b_rd_ptr].id;
    assign bus.out_bresp   = b_mem[b_rd_ptr].resp;

    // Queue storage, pointers, beat counter and status accumulators.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(SLV_OSTDREQ_NUM); i++) aw_mem[i] <= '0;
            for (int i = 0; i < int'(B_FIFO_DEPTH); i++)    b_mem[i]  <= '0;
            aw_wr_ptr     <= '0;
            aw_rd_ptr     <= '0;
            aw_cnt        <= '0;
            b_wr_ptr      <= '0;
            b_rd_ptr      <= '0;
            b_cnt         <= '0;
            cnt           <= '0;
            id_err_q      <= 1'b0;
            awready_q     <= 1'b0;
            out_err_cnt   <= '0;
            out_wdata_xor <= '0;
        end else begin
            aw_cnt    <= aw_cnt_nxt;
            b_cnt     <= b_cnt_nxt;
            awready_q <= (aw_cnt_nxt != (AW_PTR_W+1)'(SLV_OSTDREQ_NUM));
            if (aw_push) begin
                aw_mem[aw_wr_ptr] <= '{id: bus.in_awid, len: bus.in_awlen};
                aw_wr_ptr         <= aw_wr_ptr + AW_PTR_W'(1);
            end
            if (aw_pop) begin
                aw_rd_ptr <= aw_rd_ptr + AW_PTR_W'(1);
            end
            if (b_push) begin
                b_mem[b_wr_ptr] <= '{id: aw_head.id, resp: (burst_err ? 2'b10 : 2'b00)};
                b_wr_ptr        <= b_wr_ptr + B_PTR_W'(1);
                if (burst_err && out_err_cnt != 8'hFF) begin
                    out_err_cnt <= out_err_cnt + 8'd1;
                end
            end
            if (b_pop) begin
                b_rd_ptr <= b_rd_ptr + B_PTR_W'(1);
            end
            if (w_acc) begin
                out_wdata_xor <= out_wdata_xor ^ (bus.in_wdata & strb_mask);
                if (burst_end) begin
                    cnt      <= '0;
                    id_err_q <= 1'b0;
                end else begin
                    cnt      <= cnt + 4'd1;
                    id_err_q <= id_err_q || id_mis;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Bench for axi_slv_wr_responder: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_axi_slv_wr_responder;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned DW = 32;

    logic          aclk = 1'b0;
    logic          arst;
    logic [7:0]    err_cnt;
    logic [DW-1:0] wxor;

    axi_slv_wr_responder_if #(.AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW)) bus ();

    axi_slv_wr_responder #(
        .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW),
        .SLV_OSTDREQ_NUM(4), .B_FIFO_DEPTH(4)
    ) dut (
        .aclk(aclk),
        .arst(arst),
        .bus(bus),
        .out_err_cnt(err_cnt),
        .out_wdata_xor(wxor)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0] id;
        logic [3:0] len;
    } req_t;

    // Reference model state
    req_t        m_aw[$];
    logic [3:0]  m_bid[$];
    logic [1:0]  m_bresp[$];
    int unsigned m_cnt;
    bit          m_sticky;
    int unsigned m_err;
    logic [31:0] m_xor;
    bit          m_post_rst;
    bit          last_aw_hs, last_w_hs;

    // Random driver state
    req_t        drv_q[$];
    int unsigned drv_beat;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in_awvalid = 1'b0; bus.in_awaddr = '0; bus.in_awlen = '0; bus.in_awid = '0;
        bus.in_wvalid  = 1'b0; bus.in_wlast  = 1'b0; bus.in_wid = '0;
        bus.in_wdata   = '0;   bus.in_wstrb  = '0;   bus.in_wstall = 1'b0;
        bus.in_bready  = 1'b0;
    endtask

    // One clock: compare DUT outputs with the model, advance the model by the
    // handshakes the coming edge will perform, then move to the next negedge.
    task automatic step();
        bit          exp_awr, exp_wr, aw_hs, w_hs, b_hs, bad;
        req_t        h;
        logic [31:0] mask;
        #1;
        exp_awr = m_post_rst && (m_aw.size() < 4);
        exp_wr  = (m_aw.size() > 0) && (m_bid.size() < 4) && !bus.in_wstall;
        chk("awready", bus.out_awready, exp_awr);
        chk("wready", bus.out_wready, exp_wr);
        chk("bvalid", bus.out_bvalid, m_bid.size() > 0);
        if (m_bid.size() > 0) begin
            chk("bid", bus.out_bid, m_bid[0]);
            chk("bresp", bus.out_bresp, m_bresp[0]);
        end
        chk("err_cnt", err_cnt, m_err);
        chk("wdata_xor", wxor, m_xor);

        aw_hs = bus.in_awvalid && exp_awr;
        w_hs  = bus.in_wvalid && exp_wr;
        b_hs  = bus.in_bready && (m_bid.size() > 0);

        if (b_hs) begin
            void'(m_bid.pop_front());
            void'(m_bresp.pop_front());
        end
        if (w_hs) begin
            h   = m_aw[0];
            bad = m_sticky || (bus.in_wid != h.id);
            for (int i = 0; i < 4; i++) mask[i*8 +: 8] = bus.in_wstrb[i] ? 8'hFF : 8'h00;
            m_xor ^= bus.in_wdata & mask;
            if (bus.in_wlast || m_cnt == h.len) begin
                // last flag and beat count disagree: early or missing last
                if (bus.in_wlast != (m_cnt == h.len)) bad = 1'b1;
                void'(m_aw.pop_front());
                m_bid.push_back(h.id);
                m_bresp.push_back(bad ? 2'b10 : 2'b00);
                if (bad && m_err < 255) m_err++;
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else begin
                m_cnt++;
                m_sticky = bad;
            end
        end
        if (aw_hs) m_aw.push_back('{bus.in_awid, bus.in_awlen});
        last_aw_hs = aw_hs;
        last_w_hs  = w_hs;
        m_post_rst = 1'b1;
        @(negedge aclk);
    endtask

    task automatic drive(input bit awv, input logic [3:0] awid, input logic [3:0] awlen,
                         input bit wv, input logic [3:0] wid, input bit wl,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input bit stall, input bit brdy);
        bus.in_awvalid = awv; bus.in_awid = awid; bus.in_awlen = awlen; bus.in_awaddr = $urandom;
        bus.in_wvalid  = wv;  bus.in_wid  = wid;  bus.in_wlast = wl;
        bus.in_wdata   = wd;  bus.in_wstrb = ws;  bus.in_wstall = stall;
        bus.in_bready  = brdy;
        step();
    endtask

    task automatic idle(input bit brdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, brdy);
    endtask

    // Asynchronous reset starting at a negedge; outputs must clear immediately.
    task automatic do_reset();
        arst = 1'b1;
        idle_inputs();
        m_aw.delete(); m_bid.delete(); m_bresp.delete(); drv_q.delete();
        m_cnt = 0; m_sticky = 1'b0; m_err = 0; m_xor = '0; drv_beat = 0;
        #1;
        chk("rst_awready", bus.out_awready, 0);
        chk("rst_wready", bus.out_wready, 0);
        chk("rst_bvalid", bus.out_bvalid, 0);
        chk("rst_bid", bus.out_bid, 0);
        chk("rst_bresp", bus.out_bresp, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_wdata_xor", wxor, 0);
        @(negedge aclk);
        arst       = 1'b0;
        m_post_rst = 1'b0;
        step();
    endtask

    initial begin
        arst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge aclk);

        // Single clean 4-beat burst
        do_reset();
        drive(1, 5, 3, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 5, i == 3, 32'h11 * (i + 1), 4'hF, 0, 1);
        chk("t1_bvalid", bus.out_bvalid, 1);
        chk("t1_bid", bus.out_bid, 5);
        chk("t1_bresp", bus.out_bresp, 0);
        chk("t1_err_cnt", err_cnt, 0);
        repeat (2) idle(1);

        // AW queue full, fifth AW waits for a pop
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 4'(i + 1), 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_awready_full", bus.out_awready, 0);
        drive(1, 5, 0, 1, 1, 1, 32'hA5A5_0001, 4'hF, 0, 1);
        chk("t2_awready_free", bus.out_awready, 1);
        drive(1, 5, 0, 1, 2, 1, 32'hA5A5_0002, 4'hF, 0, 1);
        for (int i = 3; i <= 5; i++) drive(0, 0, 0, 1, 4'(i), 1, 32'h1000 + i, 4'hF, 0, 1);
        repeat (3) idle(1);

        // Early last, following beats belong to the next burst
        do_reset();
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 2, 1, 1, 1, 0, 32'h1, 4'hF, 0, 1);
        drive(0, 0, 0, 1, 1, 1, 32'h2, 4'hF, 0, 1);
        chk("t3_bvalid", bus.out_bvalid, 1);
        chk("t3_bresp", bus.out_bresp, 2'b10);
        chk("t3_err_cnt", err_cnt, 1);
        drive(0, 0, 0, 1, 2, 0, 32'h3, 4'hF, 0, 1);
        drive(0, 0, 0, 1, 2, 1, 32'h4, 4'hF, 0, 1);
        repeat (2) idle(1);

        // B backpressure fills the B FIFO and stalls W
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 4'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(i < 2, 5, 0, 1, 4'(i + 1), 1, 32'h77 + i, 4'hF, 0, 0);
        chk("t4_wready_bfull", bus.out_wready, 0);
        chk("t4_bvalid", bus.out_bvalid, 1);
        chk("t4_bid_first", bus.out_bid, 1);
        drive(0, 0, 0, 1, 5, 1, 32'h55, 4'hF, 0, 0);
        drive(0, 0, 0, 1, 5, 1, 32'h55, 4'hF, 0, 1);
        drive(0, 0, 0, 1, 5, 1, 32'h55, 4'hF, 0, 1);
        repeat (5) idle(1);

        // WID mismatch plus strobed XOR accumulation
        do_reset();
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 2, 0, 32'hFF00FF00, 4'hF, 0, 1);
        drive(0, 0, 0, 1, 3, 1, 32'h0000FFFF, 4'h3, 0, 1);
        chk("t5_bresp", bus.out_bresp, 2'b10);
        chk("t5_wdata_xor", wxor, 32'hFF0000FF);
        chk("t5_err_cnt", err_cnt, 1);
        idle(1);

        // Reset mid-burst drops it; a clean burst follows
        do_reset();
        drive(1, 6, 3, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 6, 0, 32'hDEAD, 4'hF, 0, 1);
        drive(0, 0, 0, 1, 6, 0, 32'hBEEF, 4'hF, 0, 1);
        do_reset();
        chk("t6_bvalid_after_rst", bus.out_bvalid, 0);
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 7, 1, 32'h1234, 4'hF, 0, 1);
        chk("t6_bvalid", bus.out_bvalid, 1);
        chk("t6_bid", bus.out_bid, 7);
        chk("t6_bresp", bus.out_bresp, 0);
        idle(1);

        // Randomized traffic with occasional protocol errors
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (last_w_hs) begin
                if (bus.in_wlast || drv_beat == drv_q[0].len) begin
                    void'(drv_q.pop_front());
                    drv_beat = 0;
                end else begin
                    drv_beat++;
                end
            end
            if (last_aw_hs) drv_q.push_back('{bus.in_awid, bus.in_awlen});
            if (!bus.in_awvalid || last_aw_hs) begin
                bus.in_awvalid = 1'($urandom_range(0, 1));
                bus.in_awid    = 4'($urandom);
                bus.in_awlen   = 4'($urandom_range(0, 3));
                bus.in_awaddr  = $urandom;
            end
            if (!bus.in_wvalid || last_w_hs) begin
                if (drv_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    bus.in_wvalid = 1'b1;
                    bus.in_wid    = ($urandom_range(0, 11) == 0) ? 4'($urandom) : drv_q[0].id;
                    bus.in_wlast  = (drv_beat == drv_q[0].len) ^ ($urandom_range(0, 15) == 0);
                    bus.in_wdata  = $urandom;
                    bus.in_wstrb  = 4'($urandom);
                end else begin
                    bus.in_wvalid = 1'b0;
                end
            end
            bus.in_wstall = ($urandom_range(0, 4) == 0);
            bus.in_bready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();
        bus.in_bready = 1'b1;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
